proc_param: RTL and testbench

PROC_PARAM -- requirements
Module: proc_param

---
 rtl/proc_param.sv | 164 ++++++++++++++++
 tb/tb_proc_param.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_param.sv
// Multi-cycle register-machine datapath: 8 GPRs, A/G staging registers and a
// four-state (T0..T3) sequencer executing mv, mvt and six ALU opcodes.
module proc_param #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DIN,
    input  logic             Run,
    output logic             Done,
    output logic             Busy,
    output logic [2:0]       Flags,
    input  logic [2:0]       DbgSel,
    output logic [WIDTH-1:0] DbgData
);

    typedef enum logic [1:0] {
        T0,
        T1,
        T2,
        T3
    } state_e;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVT = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [2:0]       flags_q, flags_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];

    // Instruction field decode from the held instruction register.
    op_e              op;
    logic             imm_mode;
    logic [2:0]       rx;
    logic [2:0]       ry;
    logic             is_move;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] mvt_value;

    assign op        = op_e'(ir_q[15:13]);
    assign imm_mode  = ir_q[12];
    assign rx        = ir_q[11:9];
    assign ry        = ir_q[2:0];
    assign is_move   = (op == OP_MV) || (op == OP_MVT);
    assign operand_b = imm_mode ? {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]} : regs_q[ry];
    assign mvt_value = {ir_q[7:0], {(WIDTH-8){1'b0}}};

    // Only DIN[15:0] carries the instruction; wider words are accepted and dropped.
    if (WIDTH > 16) begin : g_din_hi
        logic unused_din_hi;
        assign unused_din_hi = ^DIN[WIDTH-1:16];
    end

    // ALU: sum is one bit wider so the carry-out falls out of the adder.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    // NOTE: every signal written in an always_comb gets a default on entry so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, a_q} + {1'b0, operand_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                sum     = {1'b0, a_q} + {1'b0, ~operand_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_AND:  alu_res = a_q & operand_b;
            OP_OR:   alu_res = a_q | operand_b;
            OP_XOR:  alu_res = a_q ^ operand_b;
            default: alu_res = '0;
        endcase
    end

    // Sequencer and datapath next-state: at most one GPR write per cycle.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        flags_d = flags_q;
        regs_d  = regs_q;
        case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[15:0];
                    state_d = T1;
                end
            end
            T1: begin
                if (is_move) begin
                    regs_d[rx] = (op == OP_MVT) ? mvt_value : operand_b;
                    state_d    = T0;
                end else begin
                    a_d     = regs_q[rx];
                    state_d = T2;
                end
            end
            T2: begin
                g_d     = alu_res;
                flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c};
                state_d = T3;
            end
            T3: begin
                if (op != OP_CMP) begin
                    regs_d[rx] = g_q;
                end
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            flags_q <= '0;
            // NOTE: the register file is architecturally visible and must read
            // zero after reset, so it is reset explicitly rather than left as RAM.
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

    // Reset masks the state decode so a discarded instruction never signals completion.
    assign Done    = !Reset && (((state_q == T1) && is_move) || (state_q == T3));
    assign Busy    = !Reset && (state_q != T0);
    assign Flags   = flags_q;
    assign DbgData = regs_q[DbgSel];

endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param: directed cases, randomized instructions
// against an arithmetic reference model, and a WIDTH=32 instance.
module tb_proc_param;

    localparam int W   = 16;
    localparam int W32 = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   din;
    logic           run;
    logic           done;
    logic           busy;
    logic [2:0]     flags;
    logic [2:0]     dbg_sel;
    logic [W-1:0]   dbg_data;

    logic [W32-1:0] din32;
    logic           run32;
    logic           done32;
    logic           busy32;
    logic [2:0]     flags32;
    logic [2:0]     dbg_sel32;
    logic [W32-1:0] dbg_data32;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference architectural state.
    logic [W-1:0]   m_r [8];
    logic           m_n, m_z, m_c;

    logic [W-1:0]   obs_r [8];
    logic [2:0]     obs_f;
    logic [W32-1:0] obs32_r [8];
    logic [2:0]     obs32_f;

    always #5 clk = ~clk;

    proc_param #(.WIDTH(W)) u_dut (
        .Clock  (clk),
        .Reset  (rst),
        .DIN    (din),
        .Run    (run),
        .Done   (done),
        .Busy   (busy),
        .Flags  (flags),
        .DbgSel (dbg_sel),
        .DbgData(dbg_data)
    );

    proc_param #(.WIDTH(W32)) u_dut32 (
        .Clock  (clk),
        .Reset  (rst),
        .DIN    (din32),
        .Run    (run32),
        .Done   (done32),
        .Busy   (busy32),
        .Flags  (flags32),
        .DbgSel (dbg_sel32),
        .DbgData(dbg_data32)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Applies one instruction to the model; returns the expected cycle count
    // from the acceptance cycle through the Done cycle inclusive.
    function automatic int model_exec(input logic [15:0] ir);
        int op, x, y, dv;
        longint unsigned a, b, res, mask;
        op   = int'(ir[15:13]);
        x    = int'(ir[11:9]);
        y    = int'(ir[2:0]);
        dv   = int'(ir[8:0]);
        if (dv > 255) dv = dv - 512;
        mask = (64'd1 << W) - 64'd1;
        a    = longint'(m_r[x]);
        b    = ir[12] ? (longint'(dv) & mask) : longint'(m_r[y]);
        if (op == 0) begin
            m_r[x] = W'(b);
            return 2;
        end
        if (op == 1) begin
            m_r[x] = W'(longint'(ir[7:0]) << (W - 8));
            return 2;
        end
        case (op)
            2: begin res = a + b; m_c = res[W]; end
            3, 7: begin res = a - b; m_c = (a >= b); end
            4: begin res = a & b; m_c = 1'b0; end
            5: begin res = a | b; m_c = 1'b0; end
            default: begin res = a ^ b; m_c = 1'b0; end
        endcase
        res = res & mask;
        m_n = res[W-1];
        m_z = (res == 0);
        if (op != 7) m_r[x] = W'(res);
        return 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_n = 1'b0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // Presents one instruction with a single-cycle Run pulse and observes the
    // handshake; lat is 0 if Done never came within the bound.
    task automatic issue(input logic [15:0] ir, output int lat, output bit bsy_ok, output bit tail_ok);
        @(negedge clk);
        din       = W'($urandom);
        din[15:0] = ir;
        run       = 1'b1;
        @(posedge clk);
        #1;
        run    = 1'b0;
        din    = W'($urandom);
        lat    = 0;
        bsy_ok = 1'b1;
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) bsy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        tail_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic snapshot();
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            obs_r[i] = dbg_data;
        end
        obs_f = flags;
    endtask

    task automatic issue32(input logic [15:0] ir, output int lat);
        @(negedge clk);
        din32       = W32'($urandom);
        din32[15:0] = ir;
        run32       = 1'b1;
        @(posedge clk);
        #1;
        run32 = 1'b0;
        din32 = W32'($urandom);
        lat   = 0;
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            if (done32 === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic snapshot32();
        for (int i = 0; i < 8; i++) begin
            dbg_sel32 = 3'(i);
            #1;
            obs32_r[i] = dbg_data32;
        end
        obs32_f = flags32;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; run32 = 1'b0;
        din = '0; din32 = '0; dbg_sel = '0; dbg_sel32 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold_outputs: done=%b busy=%b, want 0 0", done, busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_cycle: done=%b busy=%b, want 0 0", done, busy);
        end
        snapshot();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs_r[i] !== '0) begin
                n_bad++;
                $display("FAIL reset_reg r%0d: got %h want 0", i, obs_r[i]);
            end
        end
        n_cmp++;
        if (obs_f !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000", obs_f);
        end
    endtask

    task automatic test_directed();
        logic [15:0]  t_ir  [9];
        int           t_idx [9];
        logic [W-1:0] t_val [9];
        logic [2:0]   t_fl  [9];
        int           lat, exp_lat;
        bit           bsy_ok, tail_ok;
        t_ir  = '{16'h11FF, 16'h2280, 16'h5201, 16'h15FF, 16'h1601, 16'h4403, 16'h1805, 16'hF805, 16'h7806};
        t_idx = '{0, 1, 1, 2, 3, 2, 4, 4, 4};
        t_val = '{16'hFFFF, 16'h8000, 16'h8001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0005, 16'h0005, 16'hFFFF};
        t_fl  = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b011, 3'b011, 3'b011, 3'b100};
        for (int s = 0; s < 9; s++) begin
            exp_lat = (t_ir[s][15:14] == 2'b00) ? 2 : 4;
            void'(model_exec(t_ir[s]));
            issue(t_ir[s], lat, bsy_ok, tail_ok);
            snapshot();
            n_cmp++;
            if (lat !== exp_lat) begin
                n_bad++;
                $display("FAIL dir%0d latency: got %0d want %0d", s, lat, exp_lat);
            end
            n_cmp++;
            if (!bsy_ok || !tail_ok) begin
                n_bad++;
                $display("FAIL dir%0d busy_done_shape: busy_ok=%b tail_ok=%b want 1 1", s, bsy_ok, tail_ok);
            end
            n_cmp++;
            if (obs_r[t_idx[s]] !== t_val[s]) begin
                n_bad++;
                $display("FAIL dir%0d r%0d: got %h want %h", s, t_idx[s], obs_r[t_idx[s]], t_val[s]);
            end
            n_cmp++;
            if (obs_f !== t_fl[s]) begin
                n_bad++;
                $display("FAIL dir%0d flags: got %b want %b", s, obs_f, t_fl[s]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ir;
        int          lat, exp_lat;
        bit          bsy_ok, tail_ok;
        for (int n = 0; n < 60; n++) begin
            ir      = 16'($urandom);
            exp_lat = model_exec(ir);
            issue(ir, lat, bsy_ok, tail_ok);
            snapshot();
            n_cmp++;
            if (lat !== exp_lat || !bsy_ok || !tail_ok) begin
                n_bad++;
                $display("FAIL rand%0d handshake ir=%h: lat=%0d busy_ok=%b tail_ok=%b want lat=%0d 1 1",
                         n, ir, lat, bsy_ok, tail_ok, exp_lat);
            end
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (obs_r[i] !== m_r[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d r%0d ir=%h: got %h want %h", n, i, ir, obs_r[i], m_r[i]);
                end
            end
            n_cmp++;
            if (obs_f !== {m_n, m_z, m_c}) begin
                n_bad++;
                $display("FAIL rand%0d flags ir=%h: got %b want %b", n, ir, obs_f, {m_n, m_z, m_c});
            end
        end
    endtask

    // Run held high throughout; DIN carries junk while busy and the next
    // instruction from the Done cycle onward.
    task automatic test_back_to_back();
        logic [15:0] seq [8];
        logic [2:0]  rx;
        int          lat, exp_lat;
        for (int k = 0; k < 8; k++) seq[k] = 16'($urandom);
        @(negedge clk);
        din       = W'($urandom);
        din[15:0] = seq[0];
        run       = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_lat = model_exec(seq[k]);
            rx      = seq[k][11:9];
            @(posedge clk);
            #1 din = W'($urandom);
            lat = 0;
            for (int c = 2; c < 10; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    lat = c;
                    break;
                end
            end
            if (k < 7) begin
                din       = W'($urandom);
                din[15:0] = seq[k+1];
            end else begin
                run = 1'b0;
            end
            dbg_sel = rx;
            @(posedge clk);
            #1;
            n_cmp++;
            if (lat !== exp_lat) begin
                n_bad++;
                $display("FAIL b2b%0d latency ir=%h: got %0d want %0d", k, seq[k], lat, exp_lat);
            end
            n_cmp++;
            if (dbg_data !== m_r[rx] || flags !== {m_n, m_z, m_c} || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b%0d result ir=%h: r%0d=%h flags=%b busy=%b want %h %b 0",
                         k, seq[k], rx, dbg_data, flags, busy, m_r[rx], {m_n, m_z, m_c});
            end
        end
    endtask

    task automatic test_idle_hold();
        int bad_cycles = 0;
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            din = W'($urandom);
            if (busy !== 1'b0 || done !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL idle_handshake: %0d active cycles want 0", bad_cycles);
        end
        snapshot();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs_r[i] !== m_r[i]) begin
                n_bad++;
                $display("FAIL idle_reg r%0d: got %h want %h", i, obs_r[i], m_r[i]);
            end
        end
        n_cmp++;
        if (obs_f !== {m_n, m_z, m_c}) begin
            n_bad++;
            $display("FAIL idle_flags: got %b want %b", obs_f, {m_n, m_z, m_c});
        end
    endtask

    task automatic test_reset_midflight();
        int  lat, done_seen;
        bit  bsy_ok, tail_ok;
        void'(model_exec(16'h1233));
        issue(16'h1233, lat, bsy_ok, tail_ok);
        // add r1,r2 aborted in T2
        @(negedge clk);
        din = '0; din[15:0] = 16'h4202; run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_t2_during_reset: done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_bad++;
            $display("FAIL abort_t2_after_reset: %0d active cycles want 0", done_seen);
        end
        snapshot();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs_r[i] !== '0) begin
                n_bad++;
                $display("FAIL abort_t2_reg r%0d: got %h want 0", i, obs_r[i]);
            end
        end
        n_cmp++;
        if (obs_f !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_t2_flags: got %b want 000", obs_f);
        end
        // mv r7,#0x55 with reset landing on its T1 writeback edge
        @(negedge clk);
        din = '0; din[15:0] = 16'h1E55; run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_t1_done: got %b want 0", done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        dbg_sel = 3'd7;
        #1;
        n_cmp++;
        if (dbg_data !== '0) begin
            n_bad++;
            $display("FAIL abort_t1_r7: got %h want 0", dbg_data);
        end
    endtask

    task automatic test_width32();
        int lat;
        int active = 0;
        issue32(16'h1BFF, lat);
        snapshot32();
        n_cmp++;
        if (lat !== 2 || obs32_r[5] !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL w32_mv_r5: lat=%0d r5=%h want 2 ffffffff", lat, obs32_r[5]);
        end
        issue32(16'h2CAB, lat);
        snapshot32();
        n_cmp++;
        if (lat !== 2 || obs32_r[6] !== 32'hAB00_0000 || obs32_f !== 3'b000) begin
            n_bad++;
            $display("FAIL w32_mvt_r6: lat=%0d r6=%h flags=%b want 2 ab000000 000", lat, obs32_r[6], obs32_f);
        end
        issue32(16'h5A01, lat);
        snapshot32();
        n_cmp++;
        if (lat !== 4 || obs32_r[5] !== 32'h0 || obs32_f !== 3'b011) begin
            n_bad++;
            $display("FAIL w32_add_carry: lat=%0d r5=%h flags=%b want 4 0 011", lat, obs32_r[5], obs32_f);
        end
        run32 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            din32 = W32'($urandom);
            if (busy32 !== 1'b0 || done32 !== 1'b0) active++;
        end
        snapshot32();
        n_cmp++;
        if (active !== 0 || obs32_r[6] !== 32'hAB00_0000 || obs32_r[5] !== 32'h0 || obs32_f !== 3'b011) begin
            n_bad++;
            $display("FAIL w32_idle: active=%0d r5=%h r6=%h flags=%b want 0 0 ab000000 011",
                     active, obs32_r[5], obs32_r[6], obs32_f);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs32_r[i] !== '0) begin
                n_bad++;
                $display("FAIL w32_other_reg r%0d: got %h want 0", i, obs32_r[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_idle_hold();
        test_reset_midflight();
        test_width32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
